// File: rtl/imem_boot_ctrl.sv
// Streams a program into the instruction BRAM and sequences core reset, stall and release; registered outputs, write lands 1 cycle after a beat.
// s_ready is high only in LOAD. A halted core can be reloaded without a global reset.
module imem_boot_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MAX_WORDS    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    FLUSH_CYCLES = 2,
  localparam int                   LW           = $clog2(MAX_WORDS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [LW-1:0]         load_len,
  input  logic                  halt_req,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  i_r_enb,
  output logic                  pc_stall,
  output logic                  core_rst,
  output logic                  loading,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, cnt_q;
  logic [3:0]    fcnt_q;

  logic legal, start_win, start_ok, start_bad, beat, last_beat, flush_end;
  logic core_rst_d, pc_stall_d, i_r_enb_d, loading_d, done_d;

  assign s_ready   = (state_q == LOAD);
  assign beat      = s_valid && s_ready;
  assign last_beat = beat && (cnt_q == len_q - LW'(1));
  assign flush_end = (fcnt_q == 4'(FLUSH_CYCLES - 1));
  assign legal     = (load_len != '0) && (load_len <= LW'(MAX_WORDS));
  // A reload from RUN is only honoured while the core is halted.
  assign start_win = load_start && ((state_q == IDLE) || ((state_q == RUN) && halt_req));
  assign start_ok  = start_win && legal;
  assign start_bad = start_win && !legal;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)  state_d = LOAD;
      LOAD:    if (last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = RUN;
      RUN:     if (start_ok)  state_d = LOAD;
      default:                state_d = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_comb begin
    core_rst_d = (state_d != RUN);
    pc_stall_d = (state_d == RUN) ? halt_req : 1'b1;
    i_r_enb_d  = (state_d == FLUSH) || (state_d == RUN);
    loading_d  = (state_d == LOAD);
    done_d     = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst <= 1'b1;
      pc_stall <= 1'b1;
      i_r_enb  <= 1'b0;
      loading  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      i_w_enb  <= 1'b0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      checksum <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
    end else begin
      core_rst <= core_rst_d;
      pc_stall <= pc_stall_d;
      i_r_enb  <= i_r_enb_d;
      loading  <= loading_d;
      done     <= done_d;
      i_w_enb  <= beat;
      fcnt_q   <= (state_q == FLUSH) ? fcnt_q + 4'd1 : 4'd0;
      if (beat) begin
        i_w_addr <= BASE_ADDR + (ADDR_WIDTH'(cnt_q) << 2);
        i_w_dat  <= s_data;
        checksum <= checksum ^ s_data;
        cnt_q    <= cnt_q + LW'(1);
      end
      if (start_ok) begin
        len_q    <= load_len;
        cnt_q    <= '0;
        checksum <= '0;
        error    <= 1'b0;
      end else if (start_bad) begin
        error    <= 1'b1;
      end
    end
  end

endmodule
